// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding read at a time, a single-entry instruction
// register with a valid/ready handshake, and sticky misalignment and timeout errors.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        flush,
    input  logic [63:0] pc_in,
    output logic        mem_rd_req,
    output logic [63:0] mem_addr,
    input  logic        mem_rd_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir_out,
    output logic [6:0]  ir6_0,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [63:0] pc_out,
    output logic        misaligned_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic [63:0] pc_inc;
    logic [63:0] pc_out_nxt;
    logic [31:0] ir_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic        mis_nxt;
    logic        to_nxt;

    assign mem_addr = pc;
    assign ir6_0    = ir_out[6:0];
    assign pc_inc   = pc + 64'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // flush is evaluated first so it overrides any ack or transfer in the same cycle
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        pc_out_nxt = pc_out;
        ir_nxt     = ir_out;
        cnt_nxt    = cnt;
        mis_nxt    = misaligned_err;
        to_nxt     = timeout_err;

        if (flush) begin
            state_nxt = IDLE;
            pc_nxt    = pc_in;
            cnt_nxt   = 8'd0;
            mis_nxt   = 1'b0;
            to_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        if (pc[1:0] == 2'b00) begin
                            state_nxt = REQ;
                            cnt_nxt   = 8'd0;
                        end else begin
                            state_nxt = ERR;
                            mis_nxt   = 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_rd_ack) begin
                        state_nxt  = FULL;
                        ir_nxt     = mem_rdata;
                        pc_out_nxt = pc;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ERR;
                        to_nxt    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                FULL: begin
                    if (ir_ready) begin
                        pc_nxt = pc_inc;
                        if (run && (pc_inc[1:0] == 2'b00)) begin
                            state_nxt = REQ;
                            cnt_nxt   = 8'd0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                ERR: begin
                    state_nxt = ERR;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // request and valid are registered straight from the next state, so they track it exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            pc_out         <= 64'd0;
            ir_out         <= 32'd0;
            ir_valid       <= 1'b0;
            mem_rd_req     <= 1'b0;
            cnt            <= 8'd0;
            misaligned_err <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            pc             <= pc_nxt;
            pc_out         <= pc_out_nxt;
            ir_out         <= ir_nxt;
            ir_valid       <= (state_nxt == FULL);
            mem_rd_req     <= (state_nxt == REQ);
            cnt            <= cnt_nxt;
            misaligned_err <= mis_nxt;
            timeout_err    <= to_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch, stall, timeout, misalignment,
// flush-versus-ack priority, PC wrap and asynchronous reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        flush;
    logic [63:0] pc_in;
    logic        mem_rd_req;
    logic [63:0] mem_addr;
    logic        mem_rd_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ir_out;
    logic [6:0]  ir6_0;
    logic        ir_valid;
    logic        ir_ready;
    logic [63:0] pc_out;
    logic        misaligned_err;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .flush          (flush),
        .pc_in          (pc_in),
        .mem_rd_req     (mem_rd_req),
        .mem_addr       (mem_addr),
        .mem_rd_ack     (mem_rd_ack),
        .mem_rdata      (mem_rdata),
        .ir_out         (ir_out),
        .ir6_0          (ir6_0),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .pc_out         (pc_out),
        .misaligned_err (misaligned_err),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; flush = 1'b0; pc_in = 64'd0;
        mem_rd_ack = 1'b0; mem_rdata = 32'd0; ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_rd_req); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ir_valid); end
        checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        checks++; if (pc_out !== 64'd0) begin errors++; $display("FAIL rst_pc_out: got %h want 0", pc_out); end
        checks++; if (ir_out !== 32'd0) begin errors++; $display("FAIL rst_ir: got %h want 0", ir_out); end
        checks++; if ({misaligned_err, timeout_err} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b want 00", {misaligned_err, timeout_err}); end
        rst_n = 1'b1;
        tick();
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL idle_no_run: got %b want 0", mem_rd_req); end
    endtask

    task automatic test_fetch();
        run = 1'b1;
        tick();
        checks++; if (mem_rd_req !== 1'b1) begin errors++; $display("FAIL fetch_req: got %b want 1", mem_rd_req); end
        checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL fetch_addr: got %h want 0", mem_addr); end
        tick();
        tick();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid: got %b want 0", ir_valid); end
        mem_rd_ack = 1'b1; mem_rdata = 32'h00A00093;
        tick();
        mem_rd_ack = 1'b0; mem_rdata = 32'h0;
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b want 1", ir_valid); end
        checks++; if (ir_out !== 32'h00A00093) begin errors++; $display("FAIL fetch_ir: got %h want 00a00093", ir_out); end
        checks++; if (ir6_0 !== 7'h13) begin errors++; $display("FAIL fetch_op: got %h want 13", ir6_0); end
        checks++; if (pc_out !== 64'd0) begin errors++; $display("FAIL fetch_pc_out: got %h want 0", pc_out); end
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b want 0", mem_rd_req); end
    endtask

    task automatic test_stall();
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ir_out !== 32'h00A00093 || ir_valid !== 1'b1 || mem_rd_req !== 1'b0) begin
                errors++; $display("FAIL stall_%0d: ir=%h v=%b req=%b want 00a00093/1/0", i, ir_out, ir_valid, mem_rd_req);
            end
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL xfer_valid: got %b want 0", ir_valid); end
        checks++; if (mem_rd_req !== 1'b1) begin errors++; $display("FAIL xfer_req: got %b want 1", mem_rd_req); end
        checks++; if (mem_addr !== 64'd4) begin errors++; $display("FAIL xfer_addr: got %h want 4", mem_addr); end
    endtask

    task automatic test_timeout();
        repeat (15) tick();
        checks++; if (mem_rd_req !== 1'b1 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_early: req=%b to=%b want 1/0", mem_rd_req, timeout_err);
        end
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout_err); end
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL to_req: got %b want 0", mem_rd_req); end
        mem_rd_ack = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_rd_ack = 1'b0;
        tick();
        checks++; if (ir_valid !== 1'b0 || mem_rd_req !== 1'b0 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL err_hold: v=%b req=%b to=%b want 0/0/1", ir_valid, mem_rd_req, timeout_err);
        end
        flush = 1'b1; pc_in = 64'h100;
        tick();
        flush = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
        tick();
        checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 64'h100) begin
            errors++; $display("FAIL to_refetch: req=%b addr=%h want 1/100", mem_rd_req, mem_addr);
        end
        mem_rd_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rd_ack = 1'b0;
        checks++; if (ir6_0 !== 7'h6F || pc_out !== 64'h100) begin
            errors++; $display("FAIL to_data: op=%h pc_out=%h want 6f/100", ir6_0, pc_out);
        end
        run = 1'b0; ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        tick();
        checks++; if (mem_rd_req !== 1'b0 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL run_low_idle: req=%b v=%b want 0/0", mem_rd_req, ir_valid);
        end
    endtask

    task automatic test_misaligned();
        flush = 1'b1; pc_in = 64'h102;
        tick();
        flush = 1'b0;
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL mis_pre: got %b want 0", misaligned_err); end
        run = 1'b1;
        tick();
        checks++; if (misaligned_err !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", misaligned_err); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL mis_req_%0d: got %b want 0", i, mem_rd_req); end
            tick();
        end
    endtask

    task automatic test_flush_ack();
        flush = 1'b1; pc_in = 64'h200;
        tick();
        flush = 1'b0;
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", misaligned_err); end
        tick();
        checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 64'h200) begin
            errors++; $display("FAIL fa_req: req=%b addr=%h want 1/200", mem_rd_req, mem_addr);
        end
        mem_rd_ack = 1'b1; mem_rdata = 32'hCAFEF00D; flush = 1'b1; pc_in = 64'h300;
        tick();
        mem_rd_ack = 1'b0; flush = 1'b0;
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL fa_valid: got %b want 0", ir_valid); end
        checks++; if (ir_out !== 32'hDEADBEEF || pc_out !== 64'h100) begin
            errors++; $display("FAIL fa_discard: ir=%h pc_out=%h want deadbeef/100", ir_out, pc_out);
        end
        tick();
        checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 64'h300 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL fa_next: req=%b addr=%h v=%b want 1/300/0", mem_rd_req, mem_addr, ir_valid);
        end
    endtask

    task automatic test_wrap();
        flush = 1'b1; pc_in = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        flush = 1'b0;
        tick();
        checks++; if (mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffffffffffc", mem_addr); end
        mem_rd_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_rd_ack = 1'b0;
        checks++; if (ir_valid !== 1'b1 || pc_out !== 64'hFFFF_FFFF_FFFF_FFFC || ir6_0 !== 7'h78) begin
            errors++; $display("FAIL wrap_full: v=%b pc_out=%h op=%h want 1/fffffffffffffffc/78", ir_valid, pc_out, ir6_0);
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        checks++; if (mem_addr !== 64'd0 || mem_rd_req !== 1'b1 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_next: addr=%h req=%b v=%b want 0/1/0", mem_addr, mem_rd_req, ir_valid);
        end
    endtask

    task automatic test_async_reset();
        flush = 1'b1; pc_in = 64'h40;
        tick();
        flush = 1'b0;
        tick();
        mem_rd_ack = 1'b1; mem_rdata = 32'h00000013;
        tick();
        mem_rd_ack = 1'b0;
        checks++; if (ir_valid !== 1'b1 || mem_addr !== 64'h40) begin
            errors++; $display("FAIL ar_full: v=%b addr=%h want 1/40", ir_valid, mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", ir_valid); end
        checks++; if (mem_addr !== 64'd0 || pc_out !== 64'd0 || ir_out !== 32'd0) begin
            errors++; $display("FAIL ar_regs: addr=%h pc_out=%h ir=%h want 0/0/0", mem_addr, pc_out, ir_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++; if (mem_rd_req !== 1'b1) begin errors++; $display("FAIL ar_refetch: got %b want 1", mem_rd_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL ar_req_drop: got %b want 0", mem_rd_req); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_timeout();
        test_misaligned();
        test_flush_ack();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-003 Parameter TIMEOUT_CYC, default 16: maximum cycles waiting for mem_rd_ack (range 2..255).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 run  in  1  level; fetching is permitted while high.
REQ-007 flush  in  1  pulse; discard current work and redirect to pc_in.
REQ-008 pc_in  in  64  redirect target, sampled when flush=1.
REQ-009 mem_rd_req  out  1  registered read request to instruction memory.
REQ-010 mem_addr  out  64  fetch address, equal to the current PC.
REQ-011 mem_rd_ack  in  1  one-cycle response strobe, meaningful only while mem_rd_req=1.
REQ-012 mem_rdata  in  32  instruction word, valid when mem_rd_ack=1.
REQ-013 ir_out  out  32  registered instruction word feeding the immediate/sign-extend stage.
REQ-014 ir6_0  out  7  always equal to ir_out[6:0] (opcode field).
REQ-015 ir_valid  out  1  ir_out holds an unconsumed instruction.
REQ-016 ir_ready  in  1  downstream accepts; transfer occurs when ir_valid && ir_ready.
REQ-017 pc_out  out  64  address of the instruction currently in ir_out.
REQ-018 misaligned_err  out  1  sticky: fetch attempted with pc[1:0] != 0.
REQ-019 timeout_err  out  1  sticky: no mem_rd_ack within TIMEOUT_CYC cycles.

Function
REQ-020 The FSM SHALL have four states: IDLE, REQ, FULL, ERR.
REQ-021 IDLE SHALL transition to REQ when run=1 and pc[1:0]=0, and to ERR with misaligned_err set when run=1 and pc[1:0]!=0.
REQ-022 In REQ, mem_rd_req SHALL be 1 and mem_addr SHALL equal pc; in every other state mem_rd_req SHALL be 0.
REQ-023 In REQ, mem_rd_ack=1 SHALL load ir_out<=mem_rdata and pc_out<=pc, and SHALL move to FULL; ir_valid SHALL rise on the cycle after the ack.
REQ-024 An ack may arrive on the first REQ cycle; the minimum latency from REQ entry to ir_valid SHALL be 1 cycle.
REQ-025 The wait counter SHALL reset to 0 on REQ entry and increment on each REQ cycle without an ack; when it reaches TIMEOUT_CYC-1 with no ack, the block SHALL set timeout_err and go to ERR.
REQ-026 In FULL, ir_out, ir6_0 and pc_out SHALL remain stable until the transfer.
REQ-027 On transfer, pc SHALL become pc+4 (64-bit, wrapping from 2^64-4 to 0) and ir_valid SHALL drop on the next cycle.
REQ-028 After transfer, the next state SHALL be REQ if run=1 and the new pc is aligned, and IDLE otherwise.
REQ-029 There is no back-to-back overlap: at most one request is outstanding, and mem_rd_req SHALL be 0 during FULL.
REQ-030 ERR SHALL hold until flush; mem_rd_req and ir_valid SHALL be 0 in ERR.
REQ-031 flush SHALL take priority over every other event, including a simultaneous ack or transfer: pc<=pc_in, ir_valid<=0, both error flags cleared, ack data discarded, and the next state is IDLE.
REQ-032 A mem_rd_ack outside REQ SHALL be ignored.
REQ-033 run=0 SHALL not abort an outstanding REQ or FULL; it only blocks new fetches.

Reset
REQ-034 While rst_n=0, all state SHALL clear asynchronously: state=IDLE, pc=RESET_PC, pc_out=0, ir_out=0, ir_valid=0, mem_rd_req=0, counter=0, both error flags 0.
REQ-035 Reset asserted mid-REQ or mid-FULL SHALL drop mem_rd_req and ir_valid immediately, without waiting for a clock edge.

Verification
REQ-036 Reset, then run=1, with ack on the 3rd REQ cycle and mem_rdata=32'h00A00093 -> ir_out=32'h00A00093, ir6_0=7'h13, pc_out=0, ir_valid high the cycle after the ack.
REQ-037 Hold ir_ready=0 for 5 cycles, then pulse it -> ir_out stable throughout; the next mem_addr=4, and mem_rd_req rises the cycle after the transfer.
REQ-038 Never send an ack -> after 16 REQ cycles timeout_err=1, state ERR, mem_rd_req=0; a flush with pc_in=64'h100 clears the error, and the next fetch uses addr 64'h100.
REQ-039 flush with pc_in=64'h102 -> misaligned_err=1 upon run, and no mem_rd_req is issued.
REQ-040 flush in the same cycle as mem_rd_ack -> data discarded, ir_valid stays 0, and the next mem_addr equals pc_in.
REQ-041 Assert rst_n=0 between clock edges while in FULL -> ir_valid=0 and pc=RESET_PC immediately.
